// File: rtl/mips_cpu_muldiv_iter_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
interface mips_cpu_muldiv_iter_if;
    logic        start;
    logic        is_div;
    logic        sin;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, is_div, sin, in_1, in_2,
                    input  busy, done, div_zero, hi, lo);
    modport slave  (input  start, is_div, sin, in_1, in_2,
                    output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider for MULT(U)/DIV(U), 34-cycle latency.
// Optional early-out for trivial operands: define MULDIV_SHORTCUT_EN.
module mips_cpu_muldiv_iter (
    input  logic                          clk,
    input  logic                          reset,
    mips_cpu_muldiv_iter_if.slave         bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_e;

    state_e      state_q, state_d;
    logic        is_div_q, sin_q, sign_a_q, sign_b_q, dz_op_q;
    logic [31:0] orig_a_q;
    logic [63:0] mcand_q;
    logic [31:0] mplr_q;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic        divz_q, done_q;
    logic        busy;

    logic [31:0] mag_a, mag_b;
    logic        short_hit;
    logic [32:0] rem_sh;
    logic [31:0] trial;
    logic        ge;
    logic        neg;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    assign mag_a = (bus.sin && bus.in_1[31]) ? (~bus.in_1 + 32'd1) : bus.in_1;
    assign mag_b = (bus.sin && bus.in_2[31]) ? (~bus.in_2 + 32'd1) : bus.in_2;

`ifdef MULDIV_SHORTCUT_EN
    assign short_hit = bus.is_div ? ((bus.in_2 == 32'd0) || (mag_a < mag_b))
                                  : ((bus.in_1 == 32'd0) || (bus.in_2 == 32'd0));
`else
    assign short_hit = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = short_hit ? FIXUP : CALC;
            CALC:    if (cnt_q == 5'd31) state_d = FIXUP;
            FIXUP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != IDLE);
    end

    // One iteration step; the divide shifts in the next dividend bit before the trial subtract.
    always_comb begin
        rem_sh = {acc_q[63:32], acc_q[31]};
        ge     = (rem_sh >= {1'b0, mplr_q});
        trial  = rem_sh[31:0] - mplr_q;
        if (is_div_q)
            acc_d = ge ? {trial, acc_q[30:0], 1'b1} : {rem_sh[31:0], acc_q[30:0], 1'b0};
        else
            acc_d = acc_q + (mplr_q[0] ? mcand_q : 64'd0);
    end

    always_comb begin
        neg      = sin_q & (sign_a_q ^ sign_b_q);
        prod_fix = neg ? (~acc_q + 64'd1) : acc_q;
        quot_fix = neg ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix  = (sin_q && sign_a_q) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_div_q <= 1'b0;
            sin_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_op_q  <= 1'b0;
            orig_a_q <= 32'd0;
            mcand_q  <= 64'd0;
            mplr_q   <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            divz_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (bus.start) begin
                    is_div_q <= bus.is_div;
                    sin_q    <= bus.sin;
                    sign_a_q <= bus.sin & bus.in_1[31];
                    sign_b_q <= bus.sin & bus.in_2[31];
                    dz_op_q  <= (bus.in_2 == 32'd0);
                    orig_a_q <= bus.in_1;
                    mplr_q   <= mag_b;
                    cnt_q    <= 5'd0;
                    mcand_q  <= bus.is_div ? 64'd0 : {32'd0, mag_a};
                    // A skipped small divide lands with the dividend already in the remainder half.
                    if (bus.is_div)
                        acc_q <= short_hit ? {mag_a, 32'd0} : {32'd0, mag_a};
                    else
                        acc_q <= 64'd0;
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (!is_div_q) begin
                        mcand_q <= {mcand_q[62:0], 1'b0};
                        mplr_q  <= {1'b0, mplr_q[31:1]};
                    end
                end
                FIXUP: begin
                    done_q <= 1'b1;
                    if (!is_div_q) begin
                        hi_q   <= prod_fix[63:32];
                        lo_q   <= prod_fix[31:0];
                        divz_q <= 1'b0;
                    end else if (dz_op_q) begin
                        hi_q   <= orig_a_q;
                        lo_q   <= 32'hFFFF_FFFF;
                        divz_q <= 1'b1;
                    end else begin
                        hi_q   <= rem_fix;
                        lo_q   <= quot_fix;
                        divz_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.div_zero = divz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
